cache_line_mem_responder: RTL and testbench

//  Memory-side responder for the cache line-fill/write-back protocol: services
//  128-bit line reads from the I-cache and D-cache, and line writes from the
//  D-cache, out of an internal line array with programmable latency.

---
 rtl/mem_line_pkg.sv | 22 ++
 rtl/line_ram.sv | 33 +++
 rtl/cache_line_mem_responder.sv | 148 ++++++++++++++
 tb/tb_cache_line_mem_responder.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_line_pkg.sv
// Shared types for the cache line bus and the memory-side line responder.
//   LINE_W / LINE_ADDR_W : line width in bits / line address width
//   line_t, line_addr_t  : line data and line address types
//   resp_state_t         : responder transaction phases
//   req_src_t            : which cache a transaction belongs to
package mem_line_pkg;

  localparam int unsigned LINE_W      = 128;
  localparam int unsigned LINE_ADDR_W = 26;

  typedef logic [LINE_W-1:0]      line_t;
  typedef logic [LINE_ADDR_W-1:0] line_addr_t;

  typedef enum logic [1:0] {IDLE, WAIT, RESP, GAP} resp_state_t;
  typedef enum logic {SRC_I, SRC_D} req_src_t;

  // Round-robin helper: the requester that did not win last time.
  function automatic req_src_t other_src(input req_src_t s);
    return (s == SRC_I) ? SRC_D : SRC_I;
  endfunction

endpackage

// File: rtl/line_ram.sv
// Backing line array: one synchronous write port, one registered read port.
// Contents are never reset.
//   clk      : clock, rising edge
//   wr_en    : write strobe
//   wr_addr  : write line index
//   wr_data  : write line
//   rd_addr  : read line index
//   rd_data  : registered read line (old data on same-cycle read/write)
module line_ram
  import mem_line_pkg::*;
#(
  parameter int unsigned DEPTH     = 1024,
  parameter int unsigned IDX_W     = $clog2(DEPTH),
  parameter string       INIT_FILE = ""
) (
  input  logic              clk,
  input  logic              wr_en,
  input  logic [IDX_W-1:0]  wr_addr,
  input  logic [LINE_W-1:0] wr_data,
  input  logic [IDX_W-1:0]  rd_addr,
  output logic [LINE_W-1:0] rd_data
);

  line_t mem [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
    rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/cache_line_mem_responder.sv
// Memory-side responder for the cache line-fill / write-back bus. Serves
// I-cache line reads, D-cache line reads and D-cache line writes from an
// internal line array, one transaction at a time, with a fixed latency.
//   clk, reset             : clock (rising) / async active-high reset
//   reqI_cache             : I-cache line read request (level)
//   reqAddrI_mem           : I-cache line address
//   reqD_cache             : D-cache request (level)
//   reqD_cache_write       : 1 = write-back, 0 = fill
//   reqAddrD_mem           : D-cache line address
//   data_from_cache        : write-back line
//   data_to_cache          : last read line (shared by both caches)
//   read_ready_for_icache  : 1-cycle pulse, I-cache read data valid
//   read_ready_for_dcache  : 1-cycle pulse, D-cache read data valid
//   written_data_ack       : 1-cycle pulse, write-back committed
module cache_line_mem_responder
  import mem_line_pkg::*;
#(
  parameter int unsigned LATENCY   = 4,
  parameter int unsigned DEPTH     = 1024,
  parameter string       INIT_FILE = ""
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          reqI_cache,
  input  logic [25:0]   reqAddrI_mem,
  input  logic          reqD_cache,
  input  logic          reqD_cache_write,
  input  logic [25:0]   reqAddrD_mem,
  input  logic [127:0]  data_from_cache,
  output logic [127:0]  data_to_cache,
  output logic          read_ready_for_icache,
  output logic          read_ready_for_dcache,
  output logic          written_data_ack
);

  localparam int unsigned IDX_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;

  resp_state_t      state;
  logic [CNT_W-1:0] cnt;
  req_src_t         rr_last;
  req_src_t         grant_src;
  req_src_t         next_src;
  logic             grant_write;
  logic [IDX_W-1:0] grant_idx;
  line_t            grant_data;
  line_t            ram_rd_data;
  logic             ram_wr_en;
  logic             unused_addr;

  // Upper address bits alias onto the array and are intentionally dropped.
  assign unused_addr = ^{reqAddrI_mem, reqAddrD_mem};

  always_comb begin
    next_src = SRC_I;
    if (reqI_cache && reqD_cache) begin
      next_src = other_src(rr_last);
    end else if (reqD_cache) begin
      next_src = SRC_D;
    end
  end

  // The write is tied to the RESP state itself, so an async reset during
  // the transaction leaves the array untouched.
  assign ram_wr_en = (state == RESP) && grant_write;

  line_ram #(
    .DEPTH     (DEPTH),
    .IDX_W     (IDX_W),
    .INIT_FILE (INIT_FILE)
  ) u_line_ram (
    .clk     (clk),
    .wr_en   (ram_wr_en),
    .wr_addr (grant_idx),
    .wr_data (grant_data),
    .rd_addr (grant_idx),
    .rd_data (ram_rd_data)
  );

  // Pulses are registered in RESP, so they are visible during GAP; the
  // read port has been fed the latched index since grant, so its output is
  // settled long before RESP (LATENCY >= 1).
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state                 <= IDLE;
      cnt                   <= '0;
      rr_last               <= SRC_I;
      grant_src             <= SRC_I;
      grant_write           <= 1'b0;
      grant_idx             <= '0;
      grant_data            <= '0;
      data_to_cache         <= '0;
      read_ready_for_icache <= 1'b0;
      read_ready_for_dcache <= 1'b0;
      written_data_ack      <= 1'b0;
    end else begin
      read_ready_for_icache <= 1'b0;
      read_ready_for_dcache <= 1'b0;
      written_data_ack      <= 1'b0;
      case (state)
        IDLE: begin
          if (reqI_cache || reqD_cache) begin
            grant_src   <= next_src;
            rr_last     <= next_src;
            grant_write <= (next_src == SRC_D) && reqD_cache_write;
            if (next_src == SRC_I) begin
              grant_idx <= reqAddrI_mem[IDX_W-1:0];
            end else begin
              grant_idx <= reqAddrD_mem[IDX_W-1:0];
            end
            if ((next_src == SRC_D) && reqD_cache_write) begin
              grant_data <= data_from_cache;
            end
            cnt   <= CNT_W'(LATENCY - 1);
            state <= WAIT;
          end
        end
        WAIT: begin
          if (cnt == '0) begin
            state <= RESP;
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end
        RESP: begin
          if (grant_write) begin
            written_data_ack <= 1'b1;
          end else begin
            data_to_cache <= ram_rd_data;
            if (grant_src == SRC_I) begin
              read_ready_for_icache <= 1'b1;
            end else begin
              read_ready_for_dcache <= 1'b1;
            end
          end
          state <= GAP;
        end
        GAP: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cache_line_mem_responder.sv
// Self-checking bench for cache_line_mem_responder: directed protocol
// scenarios followed by randomized single transactions, compared against a
// line-array model with round-robin arbitration and fixed response latency.
module tb_cache_line_mem_responder;
  import mem_line_pkg::*;

  localparam int unsigned LAT   = 4;
  localparam int unsigned DEPTH = 1024;

  logic        clk = 1'b0;
  logic        reset;
  logic        reqI_cache;
  logic [25:0] reqAddrI_mem;
  logic        reqD_cache;
  logic        reqD_cache_write;
  logic [25:0] reqAddrD_mem;
  line_t       data_from_cache;
  line_t       data_to_cache;
  logic        read_ready_for_icache;
  logic        read_ready_for_dcache;
  logic        written_data_ack;
  logic [2:0]  pulses;

  assign pulses = {read_ready_for_icache, read_ready_for_dcache, written_data_ack};

  cache_line_mem_responder #(
    .LATENCY   (LAT),
    .DEPTH     (DEPTH),
    .INIT_FILE ("")
  ) dut (
    .clk                   (clk),
    .reset                 (reset),
    .reqI_cache            (reqI_cache),
    .reqAddrI_mem          (reqAddrI_mem),
    .reqD_cache            (reqD_cache),
    .reqD_cache_write      (reqD_cache_write),
    .reqAddrD_mem          (reqAddrD_mem),
    .data_from_cache       (data_from_cache),
    .data_to_cache         (data_to_cache),
    .read_ready_for_icache (read_ready_for_icache),
    .read_ready_for_dcache (read_ready_for_dcache),
    .written_data_ack      (written_data_ack)
  );

  always #5 clk = ~clk;

  int    n_checks = 0;
  int    n_fail   = 0;
  line_t model [DEPTH];
  bit    valid [DEPTH];
  bit    last_was_d;
  line_t last_read;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic line_t rand128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic wait_pulse(output int k, output logic [2:0] w);
    k = -1;
    w = '0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (pulses != 3'b000) begin
        k = c;
        w = pulses;
        break;
      end
    end
  endtask

  // One transaction from an idle responder; address/data inputs are
  // scrambled right after the accepting edge to prove they were captured.
  task automatic single(input bit is_d, input bit wr, input logic [25:0] addr,
                        input line_t data, input string tag);
    int          k;
    int unsigned idx;
    logic [2:0]  exp_w;
    idx = addr % DEPTH;
    k   = -1;
    if (is_d) begin
      reqD_cache       = 1'b1;
      reqD_cache_write = wr;
      reqAddrD_mem     = addr;
      data_from_cache  = data;
    end else begin
      reqI_cache   = 1'b1;
      reqAddrI_mem = addr;
    end
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (pulses != 3'b000) begin
        k = c;
        break;
      end
      if (c == 0) begin
        reqAddrI_mem    = 26'($urandom);
        reqAddrD_mem    = 26'($urandom);
        data_from_cache = rand128();
      end
    end
    exp_w = wr ? 3'b001 : (is_d ? 3'b010 : 3'b100);
    check({tag, "_latency"}, 128'(k), 128'(LAT + 1));
    check({tag, "_pulse"}, 128'(pulses), 128'(exp_w));
    if (wr) begin
      model[idx] = data;
      valid[idx] = 1'b1;
    end else begin
      last_read = model[idx];
    end
    check({tag, "_data_out"}, data_to_cache, last_read);
    reqI_cache       = 1'b0;
    reqD_cache       = 1'b0;
    reqD_cache_write = 1'b0;
    @(negedge clk);
    check({tag, "_pulse_width"}, 128'(pulses), 128'(0));
    last_was_d = is_d;
  endtask

  task automatic dual_read(input logic [25:0] ai, input logic [25:0] ad, input string tag);
    bit          d_first;
    int          k;
    logic [2:0]  w;
    int unsigned i_idx;
    int unsigned d_idx;
    i_idx   = ai % DEPTH;
    d_idx   = ad % DEPTH;
    d_first = !last_was_d;
    reqI_cache       = 1'b1;
    reqAddrI_mem     = ai;
    reqD_cache       = 1'b1;
    reqD_cache_write = 1'b0;
    reqAddrD_mem     = ad;
    wait_pulse(k, w);
    check({tag, "_first_latency"}, 128'(k), 128'(LAT + 1));
    check({tag, "_first_src"}, 128'(w), 128'(d_first ? 3'b010 : 3'b100));
    check({tag, "_first_data"}, data_to_cache, model[d_first ? d_idx : i_idx]);
    if (d_first) reqD_cache = 1'b0;
    else         reqI_cache = 1'b0;
    wait_pulse(k, w);
    check({tag, "_second_latency"}, 128'(k), 128'(LAT + 2));
    check({tag, "_second_src"}, 128'(w), 128'(d_first ? 3'b100 : 3'b010));
    last_read = model[d_first ? i_idx : d_idx];
    check({tag, "_second_data"}, data_to_cache, last_read);
    reqI_cache = 1'b0;
    reqD_cache = 1'b0;
    @(negedge clk);
    check({tag, "_pulse_width"}, 128'(pulses), 128'(0));
    last_was_d = !d_first;
  endtask

  initial begin
    int          k;
    logic [2:0]  w;
    line_t       v1;
    line_t       v2;
    int unsigned idx;
    bit          is_d;
    bit          wr;

    reset            = 1'b1;
    reqI_cache       = 1'b0;
    reqAddrI_mem     = '0;
    reqD_cache       = 1'b0;
    reqD_cache_write = 1'b0;
    reqAddrD_mem     = '0;
    data_from_cache  = '0;
    last_was_d       = 1'b0;
    last_read        = '0;
    repeat (3) @(negedge clk);
    reset = 1'b0;

    // Reset state and idle behaviour
    check("reset_data", data_to_cache, '0);
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      check("idle_pulses", 128'(pulses), 128'(0));
    end

    // Write then read back the same line
    single(1'b1, 1'b1, 26'h5, {16{8'hA5}}, "t2_write");
    single(1'b1, 1'b0, 26'h5, '0, "t2_read");

    // Simultaneous requests, round-robin order
    single(1'b1, 1'b1, 26'h9, rand128(), "t3_prewrite");
    single(1'b0, 1'b0, 26'h9, '0, "t3_iread");
    dual_read(26'h5, 26'h9, "t3_dual_dfirst");
    single(1'b1, 1'b0, 26'h5, '0, "t3_dread");
    dual_read(26'h9, 26'h5, "t3_dual_ifirst");

    // Back-to-back held I request
    reqI_cache   = 1'b1;
    reqAddrI_mem = 26'h5;
    for (int t = 0; t < 3; t++) begin
      wait_pulse(k, w);
      check("t4_latency", 128'(k), 128'((t == 0) ? LAT + 1 : LAT + 2));
      check("t4_src", 128'(w), 128'(3'b100));
      check("t4_data", data_to_cache, model[5]);
    end
    reqI_cache = 1'b0;
    last_read  = model[5];
    last_was_d = 1'b0;
    @(negedge clk);
    check("t4_pulse_width", 128'(pulses), 128'(0));

    // Reset during the wait phase of a write
    v1 = rand128();
    v2 = ~v1;
    single(1'b1, 1'b1, 26'h7, v1, "t5_prewrite");
    reqD_cache       = 1'b1;
    reqD_cache_write = 1'b1;
    reqAddrD_mem     = 26'h7;
    data_from_cache  = v2;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset            = 1'b0;
    reqD_cache       = 1'b0;
    reqD_cache_write = 1'b0;
    last_was_d       = 1'b0;
    last_read        = '0;
    check("t5_reset_data", data_to_cache, '0);
    wait_pulse(k, w);
    check("t5_no_pulse", 128'(k), 128'(-1));
    single(1'b1, 1'b0, 26'h7, '0, "t5_readback");

    // Upper address bits alias onto the array
    single(1'b0, 1'b0, 26'h0000405, '0, "t6_alias");

    // Randomized single transactions over a small line pool
    for (int n = 0; n < 24; n++) begin
      idx  = 256 + $urandom_range(0, 7);
      is_d = 1'($urandom_range(0, 1));
      wr   = is_d && 1'($urandom_range(0, 1));
      if (!valid[idx]) begin
        is_d = 1'b1;
        wr   = 1'b1;
      end
      single(is_d, wr, 26'(idx + DEPTH * $urandom_range(0, 65535)), rand128(), "rnd");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, observed no end expected end");
    $fatal(1, "watchdog");
  end

endmodule
